// File: rtl/jtag_com_pkg.sv
// rtl/jtag_com_pkg.sv - shared constants and types for the JTAG command block
// Purpose: function codes, register widths, reset defaults, LFSR seed and
//          the CAL_DLY field layout used by jtag_com and jtag_com_calseq.
package jtag_com_pkg;

   localparam int FUNC_W = 8;
   localparam int CAL_W  = 19;
   localparam int TRG_W  = 18;

   localparam logic [FUNC_W-1:0] FC_DEFAULTS = 8'h02;
   localparam logic [FUNC_W-1:0] FC_CAL_DLY  = 8'h11;
   localparam logic [FUNC_W-1:0] FC_TRG_RATE = 8'h13;
   localparam logic [FUNC_W-1:0] FC_RTRG_TOG = 8'h14;
   localparam logic [FUNC_W-1:0] FC_BURST    = 8'h20;

   localparam logic [CAL_W-1:0] CAL_DLY_DEF  = '0;
   localparam logic [TRG_W-1:0] TRG_RATE_DEF = '0;
   localparam logic [15:0]      LFSR_SEED    = 16'hACE1;

   localparam int BURST_LEN     = 16;
   localparam int BURST_GAP     = 8;
   localparam int BURST_GAP_SIM = 2;
   localparam int RTRG_DEAD     = 4;

   typedef struct packed {
      logic [4:0] inject_dly;
      logic [4:0] extpls_dly;
      logic [4:0] cal_l1a_dly;
      logic [3:0] cal_lct_dly;
   } cal_dly_t;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_BUSY = 1'b1
   } seq_state_t;

   // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward the LSB.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

endpackage

// File: rtl/jtag_com_calseq.sv
// rtl/jtag_com_calseq.sv - calibration pulse/inject sequencer
// Purpose: on a CCB pulse or inject request (gated by plsinjen_i) run a
//          7-bit count from the launch cycle and fire PULSE/INJECT, LCT_RQST
//          and CAL_GTRG at their programmed counts, then return to idle.
// Ports:   CLKCMS, rst_plsinj      clock, async active-high reset
//          ccbpls_i, ccbinj_i      requests (pulse has priority)
//          plsinjen_i              launch enable
//          cal_dly_i               delay fields
//          pulse_o, inject_o, lct_rqst_o, cal_gtrg_o   one-cycle pulses
module jtag_com_calseq
   import jtag_com_pkg::*;
(
   input  logic     CLKCMS,
   input  logic     rst_plsinj,
   input  logic     ccbpls_i,
   input  logic     ccbinj_i,
   input  logic     plsinjen_i,
   input  cal_dly_t cal_dly_i,
   output logic     pulse_o,
   output logic     inject_o,
   output logic     lct_rqst_o,
   output logic     cal_gtrg_o
);

   seq_state_t state_q, state_d;
   logic [6:0] cnt_q, cnt_d;
   logic       sel_pls_q, sel_pls_d;
   logic       pulse_q, pulse_d;
   logic       inject_q, inject_d;
   logic       lct_q, lct_d;
   logic       gtrg_q, gtrg_d;

   logic       active;
   logic       cur_pls;
   logic [6:0] cur;
   logic [6:0] t_fire, t_lct, t_gtrg;

   // The launch cycle is evaluated as count 0, so a zero delay fires on the
   // same edge that accepts the request.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_pls_d = sel_pls_q;
      pulse_d   = 1'b0;
      inject_d  = 1'b0;
      lct_d     = 1'b0;
      gtrg_d    = 1'b0;
      active    = 1'b0;
      cur       = cnt_q;
      cur_pls   = sel_pls_q;

      case (state_q)
         SEQ_IDLE: begin
            cur     = '0;
            cur_pls = ccbpls_i;
            active  = (ccbpls_i | ccbinj_i) & plsinjen_i;
         end
         SEQ_BUSY: active = 1'b1;
         default:  state_d = SEQ_IDLE;
      endcase

      t_fire = {2'b00, cur_pls ? cal_dly_i.extpls_dly : cal_dly_i.inject_dly};
      t_lct  = t_fire + {3'b000, cal_dly_i.cal_lct_dly};
      t_gtrg = t_lct + {2'b00, cal_dly_i.cal_l1a_dly};

      if (active) begin
         pulse_d   = cur_pls & (cur == t_fire);
         inject_d  = ~cur_pls & (cur == t_fire);
         lct_d     = (cur == t_lct);
         gtrg_d    = (cur == t_gtrg);
         sel_pls_d = cur_pls;
         cnt_d     = cur + 7'd1;
         state_d   = (cur == t_gtrg) ? SEQ_IDLE : SEQ_BUSY;
      end
   end

   always_ff @(posedge CLKCMS or posedge rst_plsinj) begin
      if (rst_plsinj) begin
         state_q   <= SEQ_IDLE;
         cnt_q     <= '0;
         sel_pls_q <= 1'b0;
         pulse_q   <= 1'b0;
         inject_q  <= 1'b0;
         lct_q     <= 1'b0;
         gtrg_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_pls_q <= sel_pls_d;
         pulse_q   <= pulse_d;
         inject_q  <= inject_d;
         lct_q     <= lct_d;
         gtrg_q    <= gtrg_d;
      end
   end

   assign pulse_o    = pulse_q;
   assign inject_o   = inject_q;
   assign lct_rqst_o = lct_q;
   assign cal_gtrg_o = gtrg_q;

endmodule

// File: rtl/jtag_com.sv
// rtl/jtag_com.sv - JTAG user-register command and calibration trigger block
// Purpose: BSCAN USER1 shifts an 8-bit function code into FUNC, USER2 loads
//          CAL_DLY (0x11) or TRG_RATE (0x13); commands 0x02/0x14/0x20 run
//          once after FUNC updates. Drives the calibration sequencer, the
//          16-pulse CAL_GTRG burst, PEDESTAL toggle and the random trigger.
// Ports:   CLKCMS, rst_plsinj                   clock, async active-high reset
//          JDRCK JSEL1 JSEL2 JSHIFT JUPDATE JTDI BSCAN inputs (synchronized)
//          JTDO                                 LSB of active shift register
//          CCBPLS CCBINJ CCBPED PLSINJEN        calibration requests
//          PULSE INJECT LCT_RQST CAL_GTRG RNDTRG one-cycle pulses
//          PEDESTAL                             level
//          FUNC[7:0], CAL_DLY[18:0]             register read-back
// Config:  JTAG_COM_RTRG_EN compiles in the random trigger generator.
module jtag_com
   import jtag_com_pkg::*;
#(
   parameter int SIM = 0
) (
   input  logic                CLKCMS,
   input  logic                rst_plsinj,
   input  logic                JDRCK,
   input  logic                JSEL1,
   input  logic                JSEL2,
   input  logic                JSHIFT,
   input  logic                JUPDATE,
   input  logic                JTDI,
   output logic                JTDO,
   input  logic                CCBPLS,
   input  logic                CCBINJ,
   input  logic                CCBPED,
   input  logic                PLSINJEN,
   output logic                PULSE,
   output logic                INJECT,
   output logic                LCT_RQST,
   output logic                CAL_GTRG,
   output logic                RNDTRG,
   output logic                PEDESTAL,
   output logic [FUNC_W-1:0]   FUNC,
   output logic [CAL_W-1:0]    CAL_DLY
);

   localparam int         GAP        = (SIM != 0) ? BURST_GAP_SIM : BURST_GAP;
   localparam logic [2:0] GAP_RELOAD = 3'(GAP - 1);

   logic [5:0] js1_q, js2_q;
   logic       drck_prev_q, upd_prev_q;
   logic       drck_s, sel1_s, sel2_s, shift_s, upd_s, tdi_s;
   logic       shift_en, upd_rise;

   logic [FUNC_W-1:0] sr_func_q, sr_func_d;
   logic [CAL_W-1:0]  sr_cal_q, sr_cal_d;
   logic [FUNC_W-1:0] func_q, func_d;
   cal_dly_t          cal_dly_q, cal_dly_d;
   logic              cmd_q;
   logic              jtdo_q, jtdo_d;
   logic              restore, burst_start;
   logic              trg_lsb;

   logic [4:0] burst_rem_q, burst_rem_d;
   logic [2:0] burst_gap_q, burst_gap_d;
   logic       burst_gtrg_q, burst_gtrg_d;
   logic       ped_prev_q, pedestal_q;
   logic       seq_gtrg;

   assign {drck_s, sel1_s, sel2_s, shift_s, upd_s, tdi_s} = js2_q;
   assign shift_en = drck_s & ~drck_prev_q & shift_s;
   assign upd_rise = upd_s & ~upd_prev_q;

   always_comb begin
      sr_func_d   = sr_func_q;
      sr_cal_d    = sr_cal_q;
      func_d      = func_q;
      cal_dly_d   = cal_dly_q;
      jtdo_d      = 1'b0;
      burst_rem_d = burst_rem_q;
      burst_gap_d = burst_gap_q;
      burst_gtrg_d = 1'b0;

      // cmd_q is high for the single cycle after a USER1 update.
      restore     = cmd_q & (func_q == FC_DEFAULTS);
      burst_start = cmd_q & (func_q == FC_BURST);

      if (shift_en && sel1_s)
         sr_func_d = {tdi_s, sr_func_q[FUNC_W-1:1]};
      if (shift_en && sel2_s && func_q == FC_CAL_DLY)
         sr_cal_d = {tdi_s, sr_cal_q[CAL_W-1:1]};
      if (upd_rise && sel1_s)
         func_d = sr_func_q;
      if (upd_rise && sel2_s && func_q == FC_CAL_DLY)
         cal_dly_d = cal_dly_t'(sr_cal_q);
      if (restore)
         cal_dly_d = cal_dly_t'(CAL_DLY_DEF);

      if (sel1_s)
         jtdo_d = sr_func_q[0];
      else if (sel2_s && func_q == FC_CAL_DLY)
         jtdo_d = sr_cal_q[0];
      else if (sel2_s && func_q == FC_TRG_RATE)
         jtdo_d = trg_lsb;

      // A new burst command reloads the counters, restarting any burst.
      if (burst_start) begin
         burst_rem_d = 5'(BURST_LEN);
         burst_gap_d = '0;
      end else if (burst_rem_q != '0) begin
         if (burst_gap_q == '0) begin
            burst_gtrg_d = 1'b1;
            burst_rem_d  = burst_rem_q - 5'd1;
            burst_gap_d  = GAP_RELOAD;
         end else begin
            burst_gap_d = burst_gap_q - 3'd1;
         end
      end
   end

   always_ff @(posedge CLKCMS or posedge rst_plsinj) begin
      if (rst_plsinj) begin
         js1_q        <= '0;
         js2_q        <= '0;
         drck_prev_q  <= 1'b0;
         upd_prev_q   <= 1'b0;
         sr_func_q    <= '0;
         sr_cal_q     <= '0;
         func_q       <= '0;
         cal_dly_q    <= cal_dly_t'(CAL_DLY_DEF);
         cmd_q        <= 1'b0;
         jtdo_q       <= 1'b0;
         burst_rem_q  <= '0;
         burst_gap_q  <= '0;
         burst_gtrg_q <= 1'b0;
         ped_prev_q   <= 1'b0;
         pedestal_q   <= 1'b0;
      end else begin
         js1_q        <= {JDRCK, JSEL1, JSEL2, JSHIFT, JUPDATE, JTDI};
         js2_q        <= js1_q;
         drck_prev_q  <= drck_s;
         upd_prev_q   <= upd_s;
         sr_func_q    <= sr_func_d;
         sr_cal_q     <= sr_cal_d;
         func_q       <= func_d;
         cal_dly_q    <= cal_dly_d;
         cmd_q        <= upd_rise & sel1_s;
         jtdo_q       <= jtdo_d;
         burst_rem_q  <= burst_rem_d;
         burst_gap_q  <= burst_gap_d;
         burst_gtrg_q <= burst_gtrg_d;
         ped_prev_q   <= CCBPED;
         if (CCBPED && !ped_prev_q)
            pedestal_q <= ~pedestal_q;
      end
   end

`ifdef JTAG_COM_RTRG_EN
   logic [TRG_W-1:0] sr_trg_q, trg_rate_q;
   logic             rtrg_en_q;
   logic [15:0]      lfsr_q;
   logic [2:0]       dead_q;
   logic             rnd_q;
   logic             rnd_fire;
   logic             rtrg_unused;

   // Low TRG_RATE bits are kept for read-back only.
   assign rtrg_unused = ^trg_rate_q[11:0];
   assign rnd_fire    = rtrg_en_q & (dead_q == '0) &
                        (lfsr_q[5:0] < trg_rate_q[TRG_W-1:12]);
   assign trg_lsb     = sr_trg_q[0];

   always_ff @(posedge CLKCMS or posedge rst_plsinj) begin
      if (rst_plsinj) begin
         sr_trg_q   <= '0;
         trg_rate_q <= TRG_RATE_DEF;
         rtrg_en_q  <= 1'b0;
         lfsr_q     <= LFSR_SEED;
         dead_q     <= '0;
         rnd_q      <= 1'b0;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
         if (shift_en && sel2_s && func_q == FC_TRG_RATE)
            sr_trg_q <= {tdi_s, sr_trg_q[TRG_W-1:1]};
         if (restore)
            trg_rate_q <= TRG_RATE_DEF;
         else if (upd_rise && sel2_s && func_q == FC_TRG_RATE)
            trg_rate_q <= sr_trg_q;
         if (restore)
            rtrg_en_q <= 1'b0;
         else if (cmd_q && func_q == FC_RTRG_TOG)
            rtrg_en_q <= ~rtrg_en_q;
         rnd_q <= rnd_fire;
         if (rnd_fire)
            dead_q <= 3'(RTRG_DEAD);
         else if (dead_q != '0)
            dead_q <= dead_q - 3'd1;
      end
   end

   assign RNDTRG = rnd_q;
`else
   assign trg_lsb = 1'b0;
   assign RNDTRG  = 1'b0;
`endif

   jtag_com_calseq u_calseq (
      .CLKCMS     (CLKCMS),
      .rst_plsinj (rst_plsinj),
      .ccbpls_i   (CCBPLS),
      .ccbinj_i   (CCBINJ),
      .plsinjen_i (PLSINJEN),
      .cal_dly_i  (cal_dly_q),
      .pulse_o    (PULSE),
      .inject_o   (INJECT),
      .lct_rqst_o (LCT_RQST),
      .cal_gtrg_o (seq_gtrg)
   );

   assign CAL_GTRG = seq_gtrg | burst_gtrg_q;
   assign PEDESTAL = pedestal_q;
   assign FUNC     = func_q;
   assign CAL_DLY  = cal_dly_q;
   assign JTDO     = jtdo_q;

endmodule

// File: tb/tb_jtag_com.sv
// tb/tb_jtag_com.sv - self-checking bench for jtag_com
module tb_jtag_com;

`ifdef JTAG_COM_RTRG_EN
   localparam bit RTRG_BUILD = 1'b1;
`else
   localparam bit RTRG_BUILD = 1'b0;
`endif

   logic        CLKCMS = 1'b0;
   logic        rst_plsinj = 1'b1;
   logic        JDRCK = 1'b0, JSEL1 = 1'b0, JSEL2 = 1'b0;
   logic        JSHIFT = 1'b0, JUPDATE = 1'b0, JTDI = 1'b0;
   logic        JTDO;
   logic        CCBPLS = 1'b0, CCBINJ = 1'b0, CCBPED = 1'b0, PLSINJEN = 1'b0;
   logic        PULSE, INJECT, LCT_RQST, CAL_GTRG, RNDTRG, PEDESTAL;
   logic [7:0]  FUNC;
   logic [18:0] CAL_DLY;

   jtag_com #(.SIM(0)) dut (
      .CLKCMS(CLKCMS), .rst_plsinj(rst_plsinj),
      .JDRCK(JDRCK), .JSEL1(JSEL1), .JSEL2(JSEL2), .JSHIFT(JSHIFT),
      .JUPDATE(JUPDATE), .JTDI(JTDI), .JTDO(JTDO),
      .CCBPLS(CCBPLS), .CCBINJ(CCBINJ), .CCBPED(CCBPED), .PLSINJEN(PLSINJEN),
      .PULSE(PULSE), .INJECT(INJECT), .LCT_RQST(LCT_RQST), .CAL_GTRG(CAL_GTRG),
      .RNDTRG(RNDTRG), .PEDESTAL(PEDESTAL), .FUNC(FUNC), .CAL_DLY(CAL_DLY)
   );

   always #5 CLKCMS = ~CLKCMS;

   int cyc = 0;
   int q_pls[$], q_inj[$], q_lct[$], q_gtrg[$], q_rnd[$];
   int n_cmp = 0, n_bad = 0;

   always @(posedge CLKCMS) cyc <= cyc + 1;

   // Timestamp every output pulse by the number of rising edges seen so far.
   always @(negedge CLKCMS) begin
      if (PULSE === 1'b1)    q_pls.push_back(cyc);
      if (INJECT === 1'b1)   q_inj.push_back(cyc);
      if (LCT_RQST === 1'b1) q_lct.push_back(cyc);
      if (CAL_GTRG === 1'b1) q_gtrg.push_back(cyc);
      if (RNDTRG === 1'b1)   q_rnd.push_back(cyc);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge CLKCMS);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      q_pls.delete(); q_inj.delete(); q_lct.delete(); q_gtrg.delete(); q_rnd.delete();
   endtask

   task automatic jshift(input bit use_sel2, input logic [18:0] val, input int nbits,
                         output logic tdo);
      JSEL1 = ~use_sel2; JSEL2 = use_sel2; JSHIFT = 1'b1;
      tick(4);
      for (int i = 0; i < nbits; i++) begin
         JTDI = val[i];
         tick(4);
         JDRCK = 1'b1;
         tick(4);
         JDRCK = 1'b0;
      end
      tick(4);
      tdo = JTDO;
      JSHIFT = 1'b0; JUPDATE = 1'b1;
      tick(4);
      JUPDATE = 1'b0;
      tick(4);
      JSEL1 = 1'b0; JSEL2 = 1'b0;
      tick(2);
   endtask

   task automatic set_func(input logic [7:0] v);
      logic tdo;
      jshift(1'b0, {11'd0, v}, 8, tdo);
      chk("func_tdo", 64'(tdo), 64'(v[0]));
      chk("func", 64'(FUNC), 64'(v));
   endtask

   task automatic load_cal(input logic [18:0] v);
      logic tdo;
      set_func(8'h11);
      jshift(1'b1, v, 19, tdo);
      chk("cal_tdo", 64'(tdo), 64'(v[0]));
      chk("cal_dly", 64'(CAL_DLY), 64'(v));
   endtask

   // mode 0: CCBPLS, 1: CCBINJ, 2: both (pulse wins)
   task automatic cal_run(input logic [18:0] dly, input int mode);
      int inj_d, pls_d, l1a, lct, d, t, lnch, w;
      bit busy_pls;
      inj_d = int'(dly[18:14]); pls_d = int'(dly[13:9]);
      l1a = int'(dly[8:4]); lct = int'(dly[3:0]);
      d = (mode == 1) ? inj_d : pls_d;
      t = d + lct + l1a;
      w = $urandom_range(0, 4);
      busy_pls = 1'($urandom_range(0, 1));
      clear_q();
      CCBPLS = (mode != 1); CCBINJ = (mode != 0); PLSINJEN = 1'b0;
      tick(w);
      PLSINJEN = 1'b1;
      lnch = cyc + 1;
      tick(1);
      // Requests raised while the sequence runs must be ignored.
      CCBPLS = busy_pls; CCBINJ = ~busy_pls;
      tick(t);
      CCBPLS = 1'b0; CCBINJ = 1'b0; PLSINJEN = 1'b0;
      tick(6);
      chk("seq_pls_n", 64'(q_pls.size()), 64'(mode != 1));
      chk("seq_inj_n", 64'(q_inj.size()), 64'(mode == 1));
      chk("seq_fire_t", 64'((mode == 1) ? (q_inj.size() > 0 ? q_inj[0] : -1)
                                        : (q_pls.size() > 0 ? q_pls[0] : -1)), 64'(lnch + d));
      chk("seq_lct_n", 64'(q_lct.size()), 64'd1);
      chk("seq_lct_t", 64'(q_lct.size() > 0 ? q_lct[0] : -1), 64'(lnch + d + lct));
      chk("seq_gtrg_n", 64'(q_gtrg.size()), 64'd1);
      chk("seq_gtrg_t", 64'(q_gtrg.size() > 0 ? q_gtrg[0] : -1), 64'(lnch + t));
   endtask

   initial begin
      logic [18:0] v;
      logic        tdo;
      int          n, bad;

      tick(3);
      chk("rst_outs", 64'({PULSE, INJECT, LCT_RQST, CAL_GTRG, RNDTRG, PEDESTAL, JTDO}), 64'd0);
      chk("rst_func", 64'(FUNC), 64'd0);
      chk("rst_cal", 64'(CAL_DLY), 64'd0);
      rst_plsinj = 1'b0;
      tick(3);

      // Directed delay set {inject 15, extpls 13, l1a 11, lct 8}.
      v = {5'd15, 5'd13, 5'd11, 4'd8};
      load_cal(v);
      cal_run(v, 0);
      cal_run(v, 1);
      cal_run(v, 2);

      // Boundaries: all-zero delays fire everything on the launch cycle; maximum delays.
      load_cal(19'd0);
      cal_run(19'd0, 0);
      load_cal(19'h7FFFF);
      cal_run(19'h7FFFF, 1);

      for (int i = 0; i < 6; i++) begin
         v = 19'($urandom);
         load_cal(v);
         cal_run(v, $urandom_range(0, 2));
      end

      // Unknown code: USER2 update must not load CAL_DLY.
      set_func(8'h55);
      jshift(1'b1, 19'h12345, 19, tdo);
      chk("unknown_noload", 64'(CAL_DLY), 64'(v));

      // PEDESTAL toggles on rising edges only.
      CCBPED = 1'b1; tick(3);
      chk("ped_rise1", 64'(PEDESTAL), 64'd1);
      tick(3);
      chk("ped_hold", 64'(PEDESTAL), 64'd1);
      CCBPED = 1'b0; tick(3);
      CCBPED = 1'b1; tick(3);
      chk("ped_rise2", 64'(PEDESTAL), 64'd0);
      CCBPED = 1'b0; tick(2);

      // Burst: 16 CAL_GTRG pulses, 8 cycles apart.
      clear_q();
      set_func(8'h20);
      tick(150);
      chk("burst_n", 64'(q_gtrg.size()), 64'd16);
      bad = 0;
      for (int i = 1; i < q_gtrg.size(); i++)
         if (q_gtrg[i] - q_gtrg[i-1] != 8) bad++;
      chk("burst_gap", 64'(bad), 64'd0);

      // Restart: a second burst command mid-burst starts a fresh 16.
      clear_q();
      set_func(8'h20);
      tick(30);
      set_func(8'h20);
      tick(150);
      n = q_gtrg.size();
      chk("restart_n", 64'(n > 16 && n < 32), 64'd1);
      bad = 0;
      for (int i = n - 15; i < n; i++)
         if (i > 0 && q_gtrg[i] - q_gtrg[i-1] != 8) bad++;
      chk("restart_gap", 64'(bad), 64'd0);

      // Defaults command clears CAL_DLY.
      load_cal(19'h5A5A5);
      set_func(8'h02);
      tick(3);
      chk("defaults_cal", 64'(CAL_DLY), 64'd0);

      // Random trigger enable/disable.
      set_func(8'h13);
      jshift(1'b1, 19'h36000, 18, tdo);
      set_func(8'h14);
      tick(4);
      clear_q();
      tick(300);
      n = q_rnd.size();
      chk("rnd_active", 64'(n >= 20), 64'(RTRG_BUILD));
      bad = 0;
      for (int i = 1; i < n; i++)
         if (q_rnd[i] - q_rnd[i-1] < 5) bad++;
      chk("rnd_spacing", 64'(bad), 64'd0);
      set_func(8'h14);
      tick(6);
      clear_q();
      tick(200);
      chk("rnd_stopped", 64'(q_rnd.size()), 64'd0);
      set_func(8'h14);
      tick(4);
      clear_q();
      tick(100);
      chk("rnd_reenabled", 64'(q_rnd.size() >= 5), 64'(RTRG_BUILD));
      set_func(8'h02);
      set_func(8'h13);
      jshift(1'b1, 19'h36000, 18, tdo);
      tick(4);
      clear_q();
      tick(200);
      chk("rnd_after_defaults", 64'(q_rnd.size()), 64'd0);

      // Asynchronous reset during an active sequence and burst.
      load_cal({5'd31, 5'd31, 5'd15, 4'd15});
      set_func(8'h20);
      CCBPED = 1'b1; tick(3); CCBPED = 1'b0;
      CCBINJ = 1'b1; PLSINJEN = 1'b1;
      tick(1);
      CCBINJ = 1'b0; PLSINJEN = 1'b0;
      tick(10);
      rst_plsinj = 1'b1;
      #1;
      chk("arst_outs", 64'({PULSE, INJECT, LCT_RQST, CAL_GTRG, RNDTRG, PEDESTAL, JTDO}), 64'd0);
      chk("arst_regs", 64'({FUNC, CAL_DLY}), 64'd0);
      tick(3);
      rst_plsinj = 1'b0;
      clear_q();
      tick(150);
      chk("arst_quiet", 64'(q_pls.size() + q_inj.size() + q_lct.size() + q_gtrg.size() + q_rnd.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/jtag_com.md
JTAG_COM -- requirements
Module: jtag_com

Interface
REQ-001 SHALL have parameter SIM, default 0, meaning 1 shortens the burst spacing to 2 cycles for simulation.
REQ-002 SHALL have port CLKCMS  in  1  40 MHz system clock; all state on rising edge.
REQ-003 SHALL have port rst_plsinj  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports JDRCK, JSEL1, JSEL2, JSHIFT, JUPDATE, JTDI  in  1 each  BSCAN user-register signals (DRCK, USER1/USER2 select, Shift-DR, Update-DR, TDI).
REQ-005 SHALL have port JTDO  out  1  LSB of the active shift register.
REQ-006 SHALL have ports CCBPLS, CCBINJ, CCBPED  in  1 each  CCB pulse, inject and pedestal requests.
REQ-007 SHALL have port PLSINJEN  in  1  launch-phase enable.
REQ-008 SHALL have ports PULSE, INJECT, LCT_RQST, CAL_GTRG, RNDTRG  out  1 each  one-cycle pulses.
REQ-009 SHALL have port PEDESTAL  out  1  level output.
REQ-010 SHALL have port FUNC  out  8  current function code.
REQ-011 SHALL have port CAL_DLY  out  19  {inject_dly[4:0], extpls_dly[4:0], cal_l1a_dly[4:0], cal_lct_dly[3:0]}.

Function
REQ-012 SHALL pass all J* inputs through 2-flop synchronizers; one shift occurs per detected rising edge of synchronized JDRCK.
REQ-013 With JSEL1 and JSHIFT, SHALL shift JTDI into the MSB of an 8-bit register, LSB first; the JUPDATE rising edge copies it to FUNC.
REQ-014 With JSEL2 and JSHIFT, SHALL shift into a 19-bit register (FUNC=0x11) or an 18-bit register (FUNC=0x13).
REQ-015 On the JUPDATE rising edge with JSEL2, SHALL load the shift register into CAL_DLY or TRG_RATE; other codes do not load.
REQ-016 Command codes SHALL execute once, one cycle after FUNC updates: 0x02 restores all defaults, 0x14 toggles rtrg_en, 0x20 starts a burst, 0x00 does nothing.
REQ-017 Unknown codes SHALL be no-ops.
REQ-018 Calibration sequence: when idle and CCBPLS or CCBINJ is high, launch on the first cycle with PLSINJEN=1, and a 7-bit counter starts at 0.
REQ-019 PULSE (CCBPLS) or INJECT (CCBINJ) SHALL fire at count D, where D = extpls_dly or inject_dly respectively.
REQ-020 LCT_RQST SHALL fire at count D+cal_lct_dly, and CAL_GTRG at count D+cal_lct_dly+cal_l1a_dly; the sequence then returns to idle.
REQ-021 If CCBPLS and CCBINJ are both high, CCBPLS SHALL take priority.
REQ-022 Requests while the sequence is busy SHALL be ignored.
REQ-023 A delay of 0 SHALL fire on the launch cycle.
REQ-024 On a CCBPED rising edge, PEDESTAL SHALL toggle.
REQ-025 A burst SHALL issue 16 CAL_GTRG pulses spaced 8 cycles apart (2 if SIM=1), ORed with the calibration CAL_GTRG.
REQ-026 A burst command received during an active burst SHALL restart the burst.
REQ-027 Random trigger: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1) advances every cycle.
REQ-028 When rtrg_en=1, RNDTRG SHALL fire when LFSR[5:0] < TRG_RATE[17:12], with 4 dead cycles after each pulse.
REQ-029 TRG_RATE[11:0] SHALL be reserved and read as stored.

Reset
REQ-030 On rst_plsinj, FUNC, CAL_DLY, TRG_RATE, rtrg_en, PEDESTAL, all pulse outputs, JTDO and all counters SHALL be 0.
REQ-031 On rst_plsinj, the LFSR SHALL load its seed.
REQ-032 On rst_plsinj, sequences and bursts SHALL abort immediately.

Configuration
REQ-033 Macro JTAG_COM_RTRG_EN defined SHALL compile the random trigger generator in.
REQ-034 Without JTAG_COM_RTRG_EN, RNDTRG SHALL be tied to 0, and codes 0x13/0x14 are accepted as no-ops with TRG_RATE held at 0.

Structure
REQ-035 Package jtag_com_pkg SHALL hold the function-code constants, register widths, defaults, LFSR seed and the CAL_DLY field typedef.
REQ-036 The calibration sequencer SHALL be sub-module jtag_com_calseq.

Verification
REQ-037 Shift FUNC=0x11 then CAL_DLY {15,13,11,8}, then assert CCBPLS -> PULSE at count 13, LCT_RQST at 21, CAL_GTRG at 32 after launch.
REQ-038 With CAL_DLY {15,13,11,8}, assert CCBINJ -> INJECT at count 15, LCT_RQST at 23, CAL_GTRG at 34.
REQ-039 Run FUNC=0x13 with data 0x36000, then FUNC=0x14 -> RNDTRG pulses appear, at least 5 cycles apart; a second 0x14 stops them.
REQ-040 Run FUNC=0x20 -> exactly 16 CAL_GTRG pulses, 8 cycles apart.
REQ-041 Run FUNC=0x02 after loading CAL_DLY -> CAL_DLY reads 0 and rtrg_en reads 0.
REQ-042 Assert rst_plsinj during an active sequence -> all outputs 0 within the same cycle and no further pulses.
